fft_arbiter: RTL and testbench

FFT_ARBITER -- requirements
Module: fft_arbiter

---
 rtl/fft_arb_pkg.sv | 23 ++
 rtl/fft_arbiter_rr_picker.sv | 24 ++
 rtl/fft_arbiter.sv | 150 +++++++++++++++
 tb/tb_fft_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_arb_pkg.sv
// Shared types and constants for the FFT-engine arbiter: state encoding,
// requester count, requester id type and a one-hot helper.
package fft_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
        logic [NUM_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/fft_arbiter_rr_picker.sv
// Combinational round-robin winner selection for two requesters.
// The requester that was not served last gets first look; a lone
// request always wins regardless of history.
module rr_picker
    import fft_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            last,
    output req_id_t            win,
    output logic               any
);

    // pick the other requester first, fall back to the last-served one
    always_comb begin
        any = |req;
        win = last;
        if (req[~last]) begin
            win = ~last;
        end else if (req[last]) begin
            win = last;
        end
    end

endmodule

// File: rtl/fft_arbiter.sv
// Arbiter sharing one FFT engine between two requesters.
// Optional build macro FFT_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// forces completion with an err pulse after TIMEOUT_CYCLES without a
// valid edge; without it err is tied low and WAIT waits indefinitely.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no grant; pick a winner as soon as any req is high
// LAUNCH | one cycle, fft_start pulsed, direction already latched
// WAIT   | grant held, waiting for a fresh rising edge of valid
// DONE   | one cycle, done[id] (and err on timeout) pulsed
module fft_arbiter #(
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int NUM_REQ        = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_fwd_inv,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               fft_start,
    output logic               fft_fwd_inv,
    input  logic               fft_data_valid,
    output logic               busy,
    output logic               err
);

    import fft_arb_pkg::*;

    if (NUM_REQ != fft_arb_pkg::NUM_REQ) begin : g_bad_num_req
        $error("fft_arbiter supports exactly two requesters");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fft_arbiter TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t state;
    req_id_t    cur_id;
    req_id_t    last_id;
    req_id_t    pick_id;
    logic       pick_any;
    logic       valid_q;
    logic       valid_rise;

    // A level that is already high when WAIT starts must not count,
    // so completion keys off a registered edge rather than the level.
    assign valid_rise = fft_data_valid & ~valid_q;

    rr_picker u_rr_picker (
        .req  (req),
        .last (last_id),
        .win  (pick_id),
        .any  (pick_any)
    );

    // delayed copy of the engine valid level for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= fft_data_valid;
        end
    end

`ifdef FFT_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expired;

    assign wd_expired = (wd_cnt == '0);

    // watchdog down-counter: loaded in LAUNCH, counts down through WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= CNT_LOAD;
        end else if (state == S_LAUNCH) begin
            wd_cnt <= CNT_LOAD;
        end else if (state == S_WAIT && !wd_expired) begin
            wd_cnt <= wd_cnt - CNT_W'(1);
        end
    end
`else
    assign err = 1'b0;
`endif

    // sequencing FSM; every output is registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cur_id      <= '0;
            last_id     <= req_id_t'(1);
            gnt         <= '0;
            done        <= '0;
            fft_start   <= 1'b0;
            busy        <= 1'b0;
            fft_fwd_inv <= 1'b1;
`ifdef FFT_ARB_TIMEOUT_EN
            err         <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        state       <= S_LAUNCH;
                        cur_id      <= pick_id;
                        last_id     <= pick_id;
                        gnt         <= id_to_onehot(pick_id);
                        fft_start   <= 1'b1;
                        busy        <= 1'b1;
                        fft_fwd_inv <= req_fwd_inv[pick_id];
                    end
                end
                S_LAUNCH: begin
                    state     <= S_WAIT;
                    fft_start <= 1'b0;
                end
                S_WAIT: begin
                    // a dropped req does not abort; the transaction runs to DONE
                    if (valid_rise) begin
                        state <= S_DONE;
                        done  <= id_to_onehot(cur_id);
                    end
`ifdef FFT_ARB_TIMEOUT_EN
                    else if (wd_expired) begin
                        state <= S_DONE;
                        done  <= id_to_onehot(cur_id);
                        err   <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
`ifdef FFT_ARB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_arbiter.sv
// Directed self-checking bench for fft_arbiter. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_fft_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] fwd;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       fft_start;
    logic       fft_fwd_inv;
    logic       valid;
    logic       busy;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;
    int c_g0, c_g1, c_start, c_d0, c_d1, c_err;

    always #5 clk = ~clk;

    fft_arbiter #(
        .TIMEOUT_CYCLES (8),
        .NUM_REQ        (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_fwd_inv    (fwd),
        .gnt            (gnt),
        .done           (done),
        .fft_start      (fft_start),
        .fft_fwd_inv    (fft_fwd_inv),
        .fft_data_valid (valid),
        .busy           (busy),
        .err            (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        c_g0    += int'(gnt[0]);
        c_g1    += int'(gnt[1]);
        c_start += int'(fft_start);
        c_d0    += int'(done[0]);
        c_d1    += int'(done[1]);
        c_err   += int'(err);
    endtask

    task automatic clr();
        c_g0 = 0; c_g1 = 0; c_start = 0; c_d0 = 0; c_d1 = 0; c_err = 0;
    endtask

    initial begin
        logic [1:0] exp_g;

        // reset values
        reset = 1'b1; req = 2'b00; fwd = 2'b00; valid = 1'b0;
        clr();
        repeat (3) step();
        chk("rst_gnt",   gnt,         2'b00);
        chk("rst_done",  done,        2'b00);
        chk("rst_start", fft_start,   1'b0);
        chk("rst_busy",  busy,        1'b0);
        chk("rst_err",   err,         1'b0);
        chk("rst_fwd",   fft_fwd_inv, 1'b1);
        reset = 1'b0;
        step();
        chk("idle_busy", busy, 1'b0);

        // single request, valid rises 20 cycles after LAUNCH
        clr();
        req = 2'b01; fwd = 2'b01;
        step();
        chk("t1_launch_gnt",   gnt,         2'b01);
        chk("t1_launch_start", fft_start,   1'b1);
        chk("t1_launch_busy",  busy,        1'b1);
        chk("t1_fwd",          fft_fwd_inv, 1'b1);
        repeat (20) step();
        chk("t1_no_early_done", c_d0, 0);
        valid = 1'b1;
        step();
        chk("t1_done",     done, 2'b01);
        chk("t1_done_err", err,  1'b0);
        req = 2'b00; valid = 1'b0;
        step();
        chk("t1_idle_gnt",  gnt,  2'b00);
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_done", done, 2'b00);
        chk("t1_gnt_cycles", c_g0,    22);
        chk("t1_start_cnt",  c_start, 1);
        chk("t1_done_cnt",   c_d0,    1);
        chk("t1_done1_cnt",  c_d1,    0);

        // contention after reset: 0,1,0,1 with 4-cycle issue spacing
        reset = 1'b1;
        step();
        reset = 1'b0;
        clr();
        req = 2'b11; fwd = 2'b10;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            step();
            chk("t2_gnt",   gnt,         32'(exp_g));
            chk("t2_start", fft_start,   1'b1);
            chk("t2_fwd",   fft_fwd_inv, 32'(exp_g[1]));
            step();
            chk("t2_wait_start", fft_start, 1'b0);
            valid = 1'b1;
            step();
            chk("t2_done", done, 32'(exp_g));
            valid = 1'b0;
            step();
            chk("t2_idle_gnt", gnt, 2'b00);
        end
        req = 2'b00;
        step();
        chk("t2_done0_cnt", c_d0,    2);
        chk("t2_done1_cnt", c_d1,    2);
        chk("t2_start_cnt", c_start, 4);

        // stale valid level must not complete the transaction
        clr();
        valid = 1'b1;
        step();
        req = 2'b01; fwd = 2'b01;
        step();
        chk("t3_gnt", gnt, 2'b01);
        repeat (5) step();
        chk("t3_no_done", c_d0, 0);
        chk("t3_busy",    busy, 1'b1);
        valid = 1'b0;
        step();
        chk("t3_still_wait", done, 2'b00);
        valid = 1'b1;
        step();
        chk("t3_done", done, 2'b01);
        req = 2'b00; valid = 1'b0;
        step();

        // req[1] drops mid-WAIT; it still completes, then requester 0 wins
        clr();
        req = 2'b11;
        step();
        chk("t4_gnt1", gnt, 2'b10);
        step();
        req = 2'b01;
        step();
        step();
        chk("t4_gnt_held", gnt,  2'b10);
        chk("t4_no_done",  done, 2'b00);
        valid = 1'b1;
        step();
        chk("t4_done1", done, 2'b10);
        valid = 1'b0;
        step();
        chk("t4_idle", gnt, 2'b00);
        step();
        chk("t4_gnt0", gnt, 2'b01);
        step();
        valid = 1'b1;
        step();
        chk("t4_done0", done, 2'b01);
        req = 2'b00; valid = 1'b0;
        step();

        // reset mid-WAIT, then normal service of requester 0
        clr();
        req = 2'b10; fwd = 2'b11;
        step();
        chk("t5_gnt1", gnt, 2'b10);
        step();
        step();
        reset = 1'b1;
        step();
        chk("t5_rst_gnt",   gnt,         2'b00);
        chk("t5_rst_busy",  busy,        1'b0);
        chk("t5_rst_done",  done,        2'b00);
        chk("t5_rst_start", fft_start,   1'b0);
        chk("t5_rst_fwd",   fft_fwd_inv, 1'b1);
        reset = 1'b0; req = 2'b01; fwd = 2'b00;
        step();
        chk("t5_gnt0",  gnt,         2'b01);
        chk("t5_start", fft_start,   1'b1);
        chk("t5_fwd",   fft_fwd_inv, 1'b0);
        step();
        valid = 1'b1;
        step();
        chk("t5_done0",     done, 2'b01);
        chk("t5_no_done1",  c_d1, 0);
        req = 2'b00; valid = 1'b0;
        step();

        // watchdog: no valid edge, direction held while input changes
        clr();
        req = 2'b10; fwd = 2'b10;
        step();
        chk("t6_gnt", gnt,         2'b10);
        chk("t6_fwd", fft_fwd_inv, 1'b1);
        fwd = 2'b00;
        repeat (8) step();
        chk("t6_no_done",  c_d1,        0);
        chk("t6_fwd_held", fft_fwd_inv, 1'b1);
`ifdef FFT_ARB_TIMEOUT_EN
        step();
        chk("t6_to_done", done, 2'b10);
        chk("t6_to_err",  err,  1'b1);
        req = 2'b00;
        step();
        chk("t6_err_clr", err, 1'b0);
        chk("t6_idle",    gnt, 2'b00);
        chk("t6_err_cnt", c_err, 1);
`else
        step();
        chk("t6_wait_done", done, 2'b00);
        chk("t6_wait_err",  err,  1'b0);
        chk("t6_wait_busy", busy, 1'b1);
        repeat (20) step();
        chk("t6_still_waiting", c_d1, 0);
        valid = 1'b1;
        step();
        chk("t6_done", done, 2'b10);
        chk("t6_err",  err,  1'b0);
        req = 2'b00; valid = 1'b0;
        step();
        chk("t6_err_cnt", c_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
